// File: rtl/bin2bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_pkg
// Description : Shared definitions for the sequential binary-to-BCD converter:
//               FSM state encoding, the fixed decimal base fed to the
//               divider, and the width of one BCD digit.
// Revision    : 1.0 - initial release
// ============================================================================
package bin2bcd_pkg;

    // Fixed divisor presented to the divider on every division
    localparam int DIV_BASE = 10;

    // Bits per packed BCD digit
    localparam int BCD_W = 4;

    // FSM state encoding
    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t WAIT  = 2'd2;
    localparam state_t OUT   = 2'd3;

endpackage : bin2bcd_pkg
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential binary-to-decimal converter that drives an
//               external restoring divider (divisor fixed at 10). Each
//               remainder becomes one BCD digit; each quotient is fed back
//               as the next dividend until it reaches zero or all digit
//               slots are filled. The packed result is offered on a
//               valid/ready output.
//
// Ports       : clk        - rising-edge clock
//               rst        - asynchronous active-high reset
//               in_valid   - input word present
//               in_ready   - block can accept a word (IDLE only)
//               in_data    - unsigned binary value
//               div_a      - dividend to divider (meaningful with div_start)
//               div_b      - divisor, constant 10
//               div_start  - one-cycle start pulse to divider
//               div_res    - divider quotient, valid with div_done
//               div_mod    - divider remainder, valid with div_done
//               div_done   - one-cycle divider completion pulse
//               out_valid  - result held and valid
//               out_ready  - downstream accepts the result
//               out_bcd    - packed BCD, digit 0 (ones) in [3:0]
//               out_ovf    - value needed more than DIGITS digits
//
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,

    output logic [WIDTH-1:0]        div_a,
    output logic [WIDTH-1:0]        div_b,
    output logic                    div_start,
    input  logic [WIDTH-1:0]        div_res,
    input  logic [WIDTH-1:0]        div_mod,
    input  logic                    div_done,

    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BCD_W*DIGITS-1:0] out_bcd,
    output logic                    out_ovf
);

    localparam int IDX_W    = $clog2(DIGITS) + 1;
    localparam int BCD_BITS = BCD_W * DIGITS;

    state_t                r_state;
    logic [WIDTH-1:0]      r_q;
    logic [IDX_W-1:0]      r_idx;
    logic [BCD_BITS-1:0]   r_bcd;
    logic                  r_ovf;
    logic                  r_start;

    logic                  w_last;
    logic                  w_unused_mod;

    // Conversion ends once the quotient is exhausted or the top digit slot
    // has just been filled; anything left in the quotient is overflow.
    assign w_last = (div_res == '0) || (r_idx == IDX_W'(DIGITS - 1));

    // The remainder is always below 10, so only its low nibble carries data.
    assign w_unused_mod = ^div_mod[WIDTH-1:BCD_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_idx   <= '0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_start <= 1'b0;
        end else begin
            // Start is a single-cycle pulse; it is raised only on entry to ISSUE.
            r_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_q     <= in_data;
                        r_idx   <= '0;
                        r_bcd   <= '0;
                        r_ovf   <= 1'b0;
                        r_start <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (div_done) begin
                        for (int d = 0; d < DIGITS; d++) begin
                            if (r_idx == IDX_W'(d)) begin
                                r_bcd[d*BCD_W +: BCD_W] <= div_mod[BCD_W-1:0];
                            end
                        end
                        r_q <= div_res;
                        if (w_last) begin
                            r_ovf   <= (div_res != '0);
                            r_state <= OUT;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_start <= 1'b1;
                            r_state <= ISSUE;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // r_q is registered and only changes on accept or on a completed
    // division, so it is stable for the whole ISSUE cycle.
    assign div_a     = r_q;
    assign div_b     = WIDTH'(DIV_BASE);
    assign div_start = r_start;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == OUT);
    assign out_bcd   = r_bcd;
    assign out_ovf   = r_ovf;

endmodule : bin2bcd_seq
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2bcd_seq
// Description : Directed self-checking bench for bin2bcd_seq. Two instances
//               (DIGITS=5 and DIGITS=3), each wired to a behavioural divider
//               that honours the start/done timing contract.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- DIGITS=5 instance ----------------
    logic         in_valid, in_ready, out_valid, out_ready, out_ovf;
    logic [W-1:0] in_data, div_a, div_b, div_res, div_mod;
    logic         div_start, div_done;
    logic [19:0]  out_bcd;

    bin2bcd_seq #(.WIDTH(W), .DIGITS(5)) u_dut5 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_start (div_start),
        .div_res   (div_res),
        .div_mod   (div_mod),
        .div_done  (div_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_ovf   (out_ovf)
    );

    // ---------------- DIGITS=3 instance ----------------
    logic         in_valid_3, in_ready_3, out_valid_3, out_ready_3, out_ovf_3;
    logic [W-1:0] in_data_3, div_a_3, div_b_3, div_res_3, div_mod_3;
    logic         div_start_3, div_done_3;
    logic [11:0]  out_bcd_3;

    bin2bcd_seq #(.WIDTH(W), .DIGITS(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_3),
        .in_ready  (in_ready_3),
        .in_data   (in_data_3),
        .div_a     (div_a_3),
        .div_b     (div_b_3),
        .div_start (div_start_3),
        .div_res   (div_res_3),
        .div_mod   (div_mod_3),
        .div_done  (div_done_3),
        .out_valid (out_valid_3),
        .out_ready (out_ready_3),
        .out_bcd   (out_bcd_3),
        .out_ovf   (out_ovf_3)
    );

    // ---------------- Divider models ----------------
    // start sampled at edge E0 -> done high in the cycle after edge E0+W.
    int           cnt5, cnt3;
    logic [W-1:0] a5, b5, a3, b3;
    int           n_st5 = 0;
    int           n_st3 = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt5 <= 0; div_done <= 1'b0; div_res <= '0; div_mod <= '0;
        end else begin
            div_done <= 1'b0;
            if (div_start) begin
                cnt5 <= W; a5 <= div_a; b5 <= div_b;
            end else if (cnt5 > 0) begin
                cnt5 <= cnt5 - 1;
                if (cnt5 == 1) begin
                    div_done <= 1'b1;
                    div_res  <= a5 / b5;
                    div_mod  <= a5 % b5;
                end
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt3 <= 0; div_done_3 <= 1'b0; div_res_3 <= '0; div_mod_3 <= '0;
        end else begin
            div_done_3 <= 1'b0;
            if (div_start_3) begin
                cnt3 <= W; a3 <= div_a_3; b3 <= div_b_3;
            end else if (cnt3 > 0) begin
                cnt3 <= cnt3 - 1;
                if (cnt3 == 1) begin
                    div_done_3 <= 1'b1;
                    div_res_3  <= a3 / b3;
                    div_mod_3  <= a3 % b3;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (div_start)   n_st5 <= n_st5 + 1;
        if (div_start_3) n_st3 <= n_st3 + 1;
    end

    // ---------------- Helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one word to the DIGITS=5 instance and check the result.
    task automatic run5(input logic [W-1:0] v, input int exp_lat, input logic [19:0] exp_bcd,
                        input logic exp_ovf, input int exp_starts, input bit do_ack);
        int lat;
        int st0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        st0      = n_st5;
        chk("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
        lat = 0;
        while (!out_valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency",   32'(lat), 32'(exp_lat));
        chk("bcd",       32'(out_bcd), 32'(exp_bcd));
        chk("ovf",       32'(out_ovf), 32'(exp_ovf));
        chk("n_starts",  32'(n_st5 - st0), 32'(exp_starts));
        chk("busy_ready", 32'(in_ready), 32'd0);
        if (do_ack) ack5();
    endtask

    task automatic ack5();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ack_valid_drop", 32'(out_valid), 32'd0);
        chk("ack_ready_back", 32'(in_ready), 32'd1);
    endtask

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- Directed sequence ----------------
    initial begin
        int  lat3;
        int  st3;
        bit  seen;

        rst         = 1'b1;
        in_valid    = 1'b0; in_data   = '0; out_ready   = 1'b0;
        in_valid_3  = 1'b0; in_data_3 = '0; out_ready_3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bcd",   32'(out_bcd),   32'd0);
        chk("rst_out_ovf",   32'(out_ovf),   32'd0);
        chk("rst_div_start", 32'(div_start), 32'd0);
        chk("rst_div_a",     32'(div_a),     32'd0);
        chk("div_b",         32'(div_b),     32'd10);
        chk("div_b_3",       32'(div_b_3),   32'd10);
        @(negedge clk);
        rst = 1'b0;

        // Main conversions
        run5(16'd1234,  72, 20'h01234, 1'b0, 4, 1'b1);
        run5(16'd0,     18, 20'h00000, 1'b0, 1, 1'b1);
        run5(16'd65535, 90, 20'h65535, 1'b0, 5, 1'b0);

        // Backpressure: result must hold while out_ready stays low
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_bcd",   32'(out_bcd),   32'h65535);
            chk("bp_ready", 32'(in_ready),  32'd0);
        end
        ack5();
        run5(16'd9, 18, 20'h00009, 1'b0, 1, 1'b1);

        // Overflow on the 3-digit instance
        @(negedge clk);
        in_valid_3 = 1'b1;
        in_data_3  = 16'd1234;
        st3        = n_st3;
        @(posedge clk); #1;
        in_valid_3 = 1'b0;
        lat3 = 0;
        while (!out_valid_3 && lat3 < 400) begin
            @(posedge clk); #1;
            lat3++;
        end
        chk("d3_latency",  32'(lat3), 32'd54);
        chk("d3_bcd",      32'(out_bcd_3), 32'h234);
        chk("d3_ovf",      32'(out_ovf_3), 32'd1);
        chk("d3_n_starts", 32'(n_st3 - st3), 32'd3);
        @(negedge clk);
        out_ready_3 = 1'b1;
        @(posedge clk); #1;
        out_ready_3 = 1'b0;
        chk("d3_ack_ready", 32'(in_ready_3), 32'd1);

        // Reset during the second WAIT of 1234
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'd1234;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (25) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_bcd",   32'(out_bcd),   32'd0);
        chk("mid_rst_out_ovf",   32'(out_ovf),   32'd0);
        chk("mid_rst_div_start", 32'(div_start), 32'd0);
        chk("mid_rst_div_a",     32'(div_a),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("no_valid_after_rst", 32'(seen), 32'd0);
        run5(16'd42, 36, 20'h00042, 1'b0, 2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_bin2bcd_seq
`default_nettype wire
